// File: rtl/rx_clkdiv_ratio_ctrl.sv
// rx_clkdiv_ratio_ctrl: safe reconfiguration of the RX clock divider ratio.
// Decodes a one-hot prescale request, requires it to hold steady, waits for
// the divider to close its current output period, then freezes the divider
// for one cycle while the new ratio is committed.
module rx_clkdiv_ratio_ctrl #(
   parameter int unsigned Width         = 8,
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned TIMEOUT       = 255
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [5:0]       Prescale,
   input  logic             Cfg_Req,
   input  logic             Div_Boundary,
   output logic [Width-1:0] Ratio,
   output logic             Div_En,
   output logic             Cfg_Ack,
   output logic             Cfg_Err,
   output logic             Busy
);

   localparam int unsigned SCW = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned TCW = $clog2(TIMEOUT + 1);
   localparam int unsigned DW  = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      STABLE   = 2'd1,
      WAIT_BND = 2'd2,
      APPLY    = 2'd3
   } state_t;

   state_t           state;
   logic [5:0]       pending;
   logic [SCW-1:0]   stab_cnt;
   logic [TCW-1:0]   tmo_cnt;
   logic [DW-1:0]    req_dec;
   logic [DW-1:0]    pend_dec;

   // One-hot prescale code to ratio; zero marks an invalid code.
   function automatic logic [DW-1:0] decode(input logic [5:0] code);
      logic [DW-1:0] r;
      case (code)
         6'b100000: r = DW'(1);
         6'b010000: r = DW'(2);
         6'b001000: r = DW'(4);
         6'b000100: r = DW'(8);
         default:   r = DW'(0);
      endcase
      return r;
   endfunction

   // Decode of the live request and of the latched pending code.
   always_comb begin
      req_dec  = decode(Prescale);
      pend_dec = decode(pending);
   end

   // Control FSM with registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         pending  <= '0;
         stab_cnt <= '0;
         tmo_cnt  <= '0;
         Ratio    <= Width'(1);
         Div_En   <= 1'b0;
         Cfg_Ack  <= 1'b0;
         Cfg_Err  <= 1'b0;
         Busy     <= 1'b0;
      end else begin
         Cfg_Ack <= 1'b0;
         Cfg_Err <= 1'b0;
         case (state)
            IDLE: begin
               Div_En <= 1'b1;
               Busy   <= 1'b0;
               if (Cfg_Req) begin
                  pending <= Prescale;
                  if (req_dec == '0) begin
                     Cfg_Err <= 1'b1;
                  end else if (Width'(req_dec) == Ratio) begin
                     Cfg_Ack <= 1'b1;
                  end else begin
                     state    <= STABLE;
                     stab_cnt <= '0;
                     Busy     <= 1'b1;
                  end
               end
            end
            STABLE: begin
               // Any wobble of the requested code aborts the request.
               if (Prescale != pending) begin
                  Cfg_Err  <= 1'b1;
                  Busy     <= 1'b0;
                  stab_cnt <= '0;
                  state    <= IDLE;
               end else if (stab_cnt == SCW'(STABLE_CYCLES - 1)) begin
                  stab_cnt <= '0;
                  tmo_cnt  <= '0;
                  state    <= WAIT_BND;
               end else begin
                  stab_cnt <= stab_cnt + SCW'(1);
               end
            end
            WAIT_BND: begin
               // A boundary on the last allowed cycle still commits.
               if (Div_Boundary) begin
                  Div_En <= 1'b0;
                  state  <= APPLY;
               end else if (tmo_cnt == TCW'(TIMEOUT - 1)) begin
                  Cfg_Err <= 1'b1;
                  Busy    <= 1'b0;
                  tmo_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TCW'(1);
               end
            end
            APPLY: begin
               Ratio   <= Width'(pend_dec);
               Cfg_Ack <= 1'b1;
               Div_En  <= 1'b1;
               Busy    <= 1'b0;
               tmo_cnt <= '0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_clkdiv_ratio_ctrl.sv
// Testbench for rx_clkdiv_ratio_ctrl: directed scenarios plus randomized
// transactions checked against a cycle-indexed outcome model.
module tb_rx_clkdiv_ratio_ctrl;

   localparam int S   = 4;
   localparam int TO  = 255;
   localparam int MAXK = 300;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] prescale = 6'b100000;
   logic       cfg_req = 1'b0;
   logic       div_boundary = 1'b0;
   logic [7:0] ratio;
   logic       div_en;
   logic       cfg_ack;
   logic       cfg_err;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int model_ratio = 1;

   logic       o_ack   [MAXK];
   logic       o_err   [MAXK];
   logic       o_busy  [MAXK];
   logic       o_den   [MAXK];
   logic [7:0] o_ratio [MAXK];

   rx_clkdiv_ratio_ctrl #(
      .Width(8),
      .STABLE_CYCLES(S),
      .TIMEOUT(TO)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .Prescale(prescale),
      .Cfg_Req(cfg_req),
      .Div_Boundary(div_boundary),
      .Ratio(ratio),
      .Div_En(div_en),
      .Cfg_Ack(cfg_ack),
      .Cfg_Err(cfg_err),
      .Busy(busy)
   );

   always #5 clk = ~clk;

   // Reference decode: single set bit at position p (5..2) gives 2^(5-p).
   function automatic int ref_ratio(input logic [5:0] c);
      int pos;
      pos = -1;
      if ($countones(c) != 1) return 0;
      for (int i = 0; i < 6; i++) if (c[i]) pos = i;
      if (pos < 2) return 0;
      return 1 << (5 - pos);
   endfunction

   // Drives one request (cycle k=0 is T) and records outputs for k=0..ncyc.
   // noise: 0 quiet, 1 random req/boundary/prescale where ignored, 2 req held high.
   task automatic run_txn(input logic [5:0] code, input int bnd_k, input int sw_k,
                          input int ncyc, input int noise, input int noise_end);
      for (int k = 0; k <= ncyc; k++) begin
         @(negedge clk);
         o_ack[k]   = cfg_ack;
         o_err[k]   = cfg_err;
         o_busy[k]  = busy;
         o_den[k]   = div_en;
         o_ratio[k] = ratio;
         cfg_req      = 1'b0;
         div_boundary = 1'b0;
         prescale     = code;
         if (k == 0) cfg_req = 1'b1;
         else if (k <= noise_end) begin
            if (noise == 2) cfg_req = 1'b1;
            else if (noise == 1) cfg_req = 1'($urandom % 2);
         end
         if (sw_k > 0 && k >= sw_k) prescale = code ^ 6'b000001;
         else if (noise == 1 && k > S && sw_k == 0) prescale = 6'($urandom);
         if (noise == 1 && k >= 1 && k <= S) div_boundary = 1'($urandom % 2);
         if (k == bnd_k) div_boundary = 1'b1;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; cfg_req = 1'b0; div_boundary = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++; if (ratio !== 8'd1) begin errors++; $display("FAIL reset_ratio got %0d exp 1", ratio); end
      checks++; if (div_en !== 1'b0) begin errors++; $display("FAIL reset_den_first got %b exp 0", div_en); end
      checks++; if (cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL reset_ackerr got %b%b exp 00", cfg_ack, cfg_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (div_en !== 1'b1) begin errors++; $display("FAIL reset_den_after c%0d got %b exp 1", i, div_en); end
      end
      model_ratio = 1;
   endtask

   task automatic test_noop();
      run_txn(6'b100000, -1, 0, 3, 0, 0);
      for (int k = 0; k <= 3; k++) begin
         checks++; if (o_ack[k] !== (k == 1)) begin errors++; $display("FAIL noop_ack k=%0d got %b exp %b", k, o_ack[k], k == 1); end
         checks++; if (o_err[k] !== 1'b0 || o_busy[k] !== 1'b0 || o_den[k] !== 1'b1) begin
            errors++; $display("FAIL noop_flags k=%0d err/busy/den got %b%b%b exp 001", k, o_err[k], o_busy[k], o_den[k]); end
         checks++; if (o_ratio[k] !== 8'(model_ratio)) begin errors++; $display("FAIL noop_ratio k=%0d got %0d exp %0d", k, o_ratio[k], model_ratio); end
      end
   endtask

   task automatic test_invalid();
      run_txn(6'b000011, -1, 0, 3, 0, 0);
      for (int k = 0; k <= 3; k++) begin
         checks++; if (o_err[k] !== (k == 1)) begin errors++; $display("FAIL inv_err k=%0d got %b exp %b", k, o_err[k], k == 1); end
         checks++; if (o_ack[k] !== 1'b0 || o_busy[k] !== 1'b0 || o_den[k] !== 1'b1) begin
            errors++; $display("FAIL inv_flags k=%0d ack/busy/den got %b%b%b exp 001", k, o_ack[k], o_busy[k], o_den[k]); end
         checks++; if (o_ratio[k] !== 8'(model_ratio)) begin errors++; $display("FAIL inv_ratio k=%0d got %0d exp %0d", k, o_ratio[k], model_ratio); end
      end
   endtask

   task automatic test_valid_change();
      run_txn(6'b010000, 7, 0, 11, 0, 0);
      for (int k = 0; k <= 11; k++) begin
         checks++; if (o_den[k] !== (k != 8)) begin errors++; $display("FAIL valid_den k=%0d got %b exp %b", k, o_den[k], k != 8); end
         checks++; if (o_busy[k] !== (k >= 1 && k <= 8)) begin errors++; $display("FAIL valid_busy k=%0d got %b exp %b", k, o_busy[k], k >= 1 && k <= 8); end
         checks++; if (o_ack[k] !== (k == 9) || o_err[k] !== 1'b0) begin
            errors++; $display("FAIL valid_ackerr k=%0d got %b%b exp %b0", k, o_ack[k], o_err[k], k == 9); end
         checks++; if (o_ratio[k] !== ((k >= 9) ? 8'd2 : 8'(model_ratio))) begin
            errors++; $display("FAIL valid_ratio k=%0d got %0d exp %0d", k, o_ratio[k], (k >= 9) ? 2 : model_ratio); end
      end
      model_ratio = 2;
   endtask

   task automatic test_instability();
      run_txn(6'b001000, -1, 2, 6, 2, 2);
      for (int k = 0; k <= 6; k++) begin
         checks++; if (o_err[k] !== (k == 3) || o_ack[k] !== 1'b0) begin
            errors++; $display("FAIL unstable_ackerr k=%0d got %b%b exp 0%b", k, o_ack[k], o_err[k], k == 3); end
         checks++; if (o_busy[k] !== (k >= 1 && k <= 2)) begin errors++; $display("FAIL unstable_busy k=%0d got %b exp %b", k, o_busy[k], k >= 1 && k <= 2); end
         checks++; if (o_ratio[k] !== 8'(model_ratio) || o_den[k] !== 1'b1) begin
            errors++; $display("FAIL unstable_ratio k=%0d got %0d/%b exp %0d/1", k, o_ratio[k], o_den[k], model_ratio); end
      end
   endtask

   task automatic test_timeout();
      int w;
      w = S + 1;
      run_txn(6'b000100, -1, 0, w + TO + 1, 1, w + TO - 1);
      for (int k = 0; k <= w + TO + 1; k++) begin
         checks++; if (o_err[k] !== (k == w + TO) || o_ack[k] !== 1'b0) begin
            errors++; $display("FAIL timeout_ackerr k=%0d got %b%b exp 0%b", k, o_ack[k], o_err[k], k == w + TO); end
         checks++; if (o_busy[k] !== (k >= 1 && k < w + TO) || o_den[k] !== 1'b1 || o_ratio[k] !== 8'(model_ratio)) begin
            errors++; $display("FAIL timeout_state k=%0d busy/den/ratio got %b/%b/%0d exp %b/1/%0d",
                               k, o_busy[k], o_den[k], o_ratio[k], k >= 1 && k < w + TO, model_ratio); end
      end
   endtask

   task automatic test_timeout_edge();
      int b;
      b = S + TO;
      run_txn(6'b000100, b, 0, b + 3, 1, b + 1);
      for (int k = 0; k <= b + 3; k++) begin
         checks++; if (o_ack[k] !== (k == b + 2) || o_err[k] !== 1'b0) begin
            errors++; $display("FAIL tedge_ackerr k=%0d got %b%b exp %b0", k, o_ack[k], o_err[k], k == b + 2); end
         checks++; if (o_den[k] !== (k != b + 1)) begin errors++; $display("FAIL tedge_den k=%0d got %b exp %b", k, o_den[k], k != b + 1); end
         checks++; if (o_ratio[k] !== ((k >= b + 2) ? 8'd8 : 8'(model_ratio))) begin
            errors++; $display("FAIL tedge_ratio k=%0d got %0d exp %0d", k, o_ratio[k], (k >= b + 2) ? 8 : model_ratio); end
      end
      model_ratio = 8;
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         logic [5:0] code;
         int dec, off, sw, ack_k, err_k, busy_last, den_k, new_k, end_k, bnd_k, r;
         r = int'($urandom % 10);
         if (r < 7) code = 6'b100000 >> ($urandom % 4);
         else code = 6'($urandom);
         r = int'($urandom % 12);
         off = (r < 10) ? int'($urandom % 6) : ((r == 10) ? TO - 1 : TO);
         sw = ($urandom % 5 == 0) ? 1 + int'($urandom % S) : 0;
         dec = ref_ratio(code);
         ack_k = -1; err_k = -1; busy_last = 0; den_k = -1; new_k = -1; bnd_k = -1;
         if (dec == 0) begin
            err_k = 1; end_k = 1;
         end else if (dec == model_ratio) begin
            ack_k = 1; end_k = 1;
         end else if (sw > 0) begin
            err_k = sw + 1; busy_last = sw; end_k = err_k;
         end else if (off < TO) begin
            bnd_k = S + 1 + off; den_k = bnd_k + 1; ack_k = bnd_k + 2;
            busy_last = bnd_k + 1; new_k = ack_k; end_k = ack_k;
         end else begin
            err_k = S + 1 + TO; busy_last = err_k - 1; end_k = err_k;
         end
         run_txn(code, bnd_k, sw, end_k + 1, 1, busy_last);
         for (int k = 0; k <= end_k + 1; k++) begin
            checks++; if (o_ack[k] !== (k == ack_k)) begin errors++; $display("FAIL rnd%0d_ack code=%b k=%0d got %b exp %b", n, code, k, o_ack[k], k == ack_k); end
            checks++; if (o_err[k] !== (k == err_k)) begin errors++; $display("FAIL rnd%0d_err code=%b k=%0d got %b exp %b", n, code, k, o_err[k], k == err_k); end
            checks++; if (o_busy[k] !== (k >= 1 && k <= busy_last)) begin
               errors++; $display("FAIL rnd%0d_busy code=%b k=%0d got %b exp %b", n, code, k, o_busy[k], k >= 1 && k <= busy_last); end
            checks++; if (o_den[k] !== (k != den_k)) begin errors++; $display("FAIL rnd%0d_den code=%b k=%0d got %b exp %b", n, code, k, o_den[k], k != den_k); end
            checks++; if (o_ratio[k] !== ((new_k >= 0 && k >= new_k) ? 8'(dec) : 8'(model_ratio))) begin
               errors++; $display("FAIL rnd%0d_ratio code=%b k=%0d got %0d exp %0d", n, code, k, o_ratio[k],
                                  (new_k >= 0 && k >= new_k) ? dec : model_ratio); end
         end
         if (new_k >= 0) model_ratio = dec;
      end
   endtask

   task automatic test_reset_midop();
      int seen;
      seen = 0;
      run_txn(6'b000100, -1, 0, S + 2, 0, 0);
      checks++; if (o_busy[S + 2] !== 1'b1) begin errors++; $display("FAIL midop_busy_before got %b exp 1", o_busy[S + 2]); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (ratio !== 8'd1 || busy !== 1'b0 || div_en !== 1'b0) begin
         errors++; $display("FAIL midop_reset ratio/busy/den got %0d/%b/%b exp 1/0/0", ratio, busy, div_en); end
      rst = 1'b0;
      for (int i = 0; i < TO + 20; i++) begin
         if (cfg_ack === 1'b1 || cfg_err === 1'b1 || busy === 1'b1 || ratio !== 8'd1) seen++;
         @(negedge clk);
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL midop_quiet got %0d active cycles exp 0", seen); end
      model_ratio = 1;
   endtask

   initial begin
      test_reset();
      test_noop();
      test_invalid();
      test_valid_change();
      test_instability();
      test_timeout();
      test_timeout_edge();
      test_random();
      test_reset();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
